// File: rtl/soc_uart_pkg.sv
// Shared definitions for the UART: register map, STAT/CTRL bit positions, serialiser states.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package soc_uart_pkg;

    // Register select values taken from addr[3:2]
    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;
    localparam logic [1:0] REG_DIV  = 2'd3;

    // STAT bit positions
    localparam int STAT_RXNE   = 0;
    localparam int STAT_TXFULL = 1;
    localparam int STAT_TXIDLE = 2;
    localparam int STAT_RXOVR  = 3;
    localparam int STAT_FRERR  = 4;
    localparam int STAT_TXOVF  = 5;

    // CTRL bit positions
    localparam int CTRL_IE_RXNE   = 0;
    localparam int CTRL_IE_TXIDLE = 1;
    localparam int CTRL_IE_ERR    = 2;

    // TX and RX walk the same frame shape, so they share one state type
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } ser_state_t;

    // A divisor below 2 would break the RX half-bit offset, so it is floored at 2
    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < 16'd2) ? 16'd2 : v;
    endfunction

endpackage

// File: rtl/soc_uart_if.sv
// Single-outstanding stb/ack register bus between the mmio decoder and the UART.
// Latency: ack one cycle after the first strobe cycle; read data valid with ack.
// Backpressure: master holds stb until ack and must drop it before the next access.
interface soc_uart_if;
    logic        stb;
    logic        rw;
    logic [3:0]  addr;
    logic [31:0] dwrite;
    logic [31:0] dread;
    logic        ack;

    modport master (output stb, rw, addr, dwrite, input  dread, ack);
    modport slave  (input  stb, rw, addr, dwrite, output dread, ack);
endinterface

// File: rtl/soc_uart_fifo.sv
// Generic synchronous FIFO, 2**FIFO_AW entries, show-ahead dout.
// Latency: push visible on dout/empty the cycle after; pop takes effect at the clock edge.
// Backpressure: push dropped when full unless a pop happens in the same cycle; pop on empty ignored.
module soc_uart_fifo #(
    parameter int WIDTH   = 8,
    parameter int FIFO_AW = 3
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam logic [FIFO_AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [2**FIFO_AW];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign dout    = mem[rd_ptr[FIFO_AW-1:0]];

    // Storage write; contents need no reset since empty masks them
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= din;
    end

    // Pointer advance, wrapping silently
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end
endmodule

// File: rtl/soc_uart.sv
// 8N1 UART slave: register file, TX FIFO + serialiser, deserialiser + RX FIFO, level irq.
// Latency: ack one cycle after first stb; irq one cycle after its cause; TX starts the cycle after FIFO non-empty.
// Backpressure: none on the bus; full TX FIFO drops writes (TXOVF), full RX FIFO drops bytes (RXOVR).
module soc_uart
    import soc_uart_pkg::*;
#(
    parameter int          FIFO_AW   = 3,
    parameter logic [15:0] DIV_RESET = 16'd104
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    soc_uart_if.slave  bus,
    output logic       o_irq,
    input  logic       i_rx,
    output logic       o_tx
);
    logic        ack_q, held_q, rd_pop_q;
    logic [31:0] dread_q, rd_val;
    logic [2:0]  ctrl_q;
    logic [15:0] div_q;
    logic        rxovr_q, frerr_q, txovf_q;
    logic        acc_start, wr_en, stat_wr, tx_idle;
    logic [1:0]  reg_sel;
    logic        unused_bits;

    logic        tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]  tx_dout;
    logic        rx_push, rx_full, rx_empty, rx_ferr;
    logic [7:0]  rx_dout;

    ser_state_t  tx_state, rx_state;
    logic [15:0] tx_cnt, rx_cnt;
    logic [2:0]  tx_bit, rx_bit;
    logic [7:0]  tx_shift, rx_shift;
    logic        tx_q;
    logic        rx_meta, rx_s, rx_d;

    assign reg_sel     = bus.addr[3:2];
    assign acc_start   = bus.stb && !ack_q && !held_q;
    assign wr_en       = ack_q && bus.rw;
    assign stat_wr     = wr_en && (reg_sel == REG_STAT);
    assign tx_push     = wr_en && (reg_sel == REG_DATA);
    assign tx_idle     = tx_empty && (tx_state == ST_IDLE);
    assign bus.ack     = ack_q;
    assign bus.dread   = dread_q;
    assign o_tx        = tx_q;
    assign unused_bits = ^{bus.dwrite[31:16], bus.addr[1:0]};

    soc_uart_fifo #(.WIDTH(8), .FIFO_AW(FIFO_AW)) u_tx_fifo (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .push(tx_push), .din(bus.dwrite[7:0]), .pop(tx_pop),
        .dout(tx_dout), .full(tx_full), .empty(tx_empty)
    );

    soc_uart_fifo #(.WIDTH(8), .FIFO_AW(FIFO_AW)) u_rx_fifo (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .push(rx_push), .din(rx_shift), .pop(rd_pop_q),
        .dout(rx_dout), .full(rx_full), .empty(rx_empty)
    );

    // Read mux, sampled at the edge that raises ack
    always_comb begin
        rd_val = '0;
        case (reg_sel)
            REG_DATA: rd_val[7:0] = rx_empty ? 8'd0 : rx_dout;
            REG_STAT: begin
                rd_val[STAT_RXNE]   = !rx_empty;
                rd_val[STAT_TXFULL] = tx_full;
                rd_val[STAT_TXIDLE] = tx_idle;
                rd_val[STAT_RXOVR]  = rxovr_q;
                rd_val[STAT_FRERR]  = frerr_q;
                rd_val[STAT_TXOVF]  = txovf_q;
            end
            REG_CTRL: rd_val[2:0]  = ctrl_q;
            default:  rd_val[15:0] = div_q;
        endcase
    end

    // One access per strobe; the RX pop is decided with the data snapshot so both agree
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ack_q    <= 1'b0;
            held_q   <= 1'b0;
            dread_q  <= '0;
            rd_pop_q <= 1'b0;
        end else begin
            ack_q    <= acc_start;
            held_q   <= bus.stb && (held_q || ack_q);
            dread_q  <= (acc_start && !bus.rw) ? rd_val : '0;
            rd_pop_q <= acc_start && !bus.rw && (reg_sel == REG_DATA) && !rx_empty;
        end
    end

    // CTRL/DIV writes land in the ack cycle
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ctrl_q <= '0;
            div_q  <= DIV_RESET;
        end else if (wr_en) begin
            if (reg_sel == REG_CTRL) ctrl_q <= bus.dwrite[2:0];
            if (reg_sel == REG_DIV)  div_q  <= clamp_div(bus.dwrite[15:0]);
        end
    end

    // Sticky error flags: write-1-to-clear, a same-cycle set wins over the clear
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rxovr_q <= 1'b0;
            frerr_q <= 1'b0;
            txovf_q <= 1'b0;
        end else begin
            if (stat_wr && bus.dwrite[STAT_RXOVR]) rxovr_q <= 1'b0;
            if (stat_wr && bus.dwrite[STAT_FRERR]) frerr_q <= 1'b0;
            if (stat_wr && bus.dwrite[STAT_TXOVF]) txovf_q <= 1'b0;
            if (rx_push && rx_full && !rd_pop_q)   rxovr_q <= 1'b1;
            if (rx_ferr)                           frerr_q <= 1'b1;
            if (tx_push && tx_full && !tx_pop)     txovf_q <= 1'b1;
        end
    end

    // Registered level interrupt
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) o_irq <= 1'b0;
        else o_irq <= (!rx_empty && ctrl_q[CTRL_IE_RXNE]) ||
                      (tx_idle && ctrl_q[CTRL_IE_TXIDLE]) ||
                      ((rxovr_q || frerr_q || txovf_q) && ctrl_q[CTRL_IE_ERR]);
    end

    // Pop when leaving IDLE or chaining STOP straight into the next START
    assign tx_pop = !tx_empty &&
                    ((tx_state == ST_IDLE) || ((tx_state == ST_STOP) && (tx_cnt == '0)));

    // Serialiser: each state holds for div_q clocks; divisor picked up at every reload
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_q     <= 1'b1;
        end else begin
            case (tx_state)
                ST_IDLE: if (!tx_empty) begin
                    tx_state <= ST_START;
                    tx_shift <= tx_dout;
                    tx_cnt   <= div_q - 16'd1;
                    tx_q     <= 1'b0;
                end
                ST_START: if (tx_cnt == '0) begin
                    tx_state <= ST_DATA;
                    tx_q     <= tx_shift[0];
                    tx_shift <= tx_shift >> 1;
                    tx_bit   <= '0;
                    tx_cnt   <= div_q - 16'd1;
                end else tx_cnt <= tx_cnt - 16'd1;
                ST_DATA: if (tx_cnt == '0) begin
                    tx_cnt <= div_q - 16'd1;
                    if (tx_bit == 3'd7) begin
                        tx_state <= ST_STOP;
                        tx_q     <= 1'b1;
                    end else begin
                        tx_bit   <= tx_bit + 3'd1;
                        tx_q     <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                    end
                end else tx_cnt <= tx_cnt - 16'd1;
                default: if (tx_cnt == '0) begin
                    if (!tx_empty) begin
                        tx_state <= ST_START;
                        tx_shift <= tx_dout;
                        tx_cnt   <= div_q - 16'd1;
                        tx_q     <= 1'b0;
                    end else tx_state <= ST_IDLE;
                end else tx_cnt <= tx_cnt - 16'd1;
            endcase
        end
    end

    // Two-flop synchroniser plus one delay stage for falling-edge detect
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign rx_push = (rx_state == ST_STOP) && (rx_cnt == '0) && rx_s;
    assign rx_ferr = (rx_state == ST_STOP) && (rx_cnt == '0) && !rx_s;

    // Deserialiser: counter ends inclusive at 0, so loading div/2-1 lands the first sample mid-start-bit
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                ST_IDLE: if (rx_d && !rx_s) begin
                    rx_state <= ST_START;
                    rx_cnt   <= (div_q >> 1) - 16'd1;
                end
                ST_START: if (rx_cnt == '0) begin
                    if (rx_s) rx_state <= ST_IDLE;
                    else begin
                        rx_state <= ST_DATA;
                        rx_bit   <= '0;
                        rx_cnt   <= div_q - 16'd1;
                    end
                end else rx_cnt <= rx_cnt - 16'd1;
                ST_DATA: if (rx_cnt == '0) begin
                    rx_shift <= {rx_s, rx_shift[7:1]};
                    rx_cnt   <= div_q - 16'd1;
                    if (rx_bit == 3'd7) rx_state <= ST_STOP;
                    else rx_bit <= rx_bit + 3'd1;
                end else rx_cnt <= rx_cnt - 16'd1;
                default: if (rx_cnt == '0) rx_state <= ST_IDLE;
                         else rx_cnt <= rx_cnt - 16'd1;
            endcase
        end
    end
endmodule

// File: tb/tb_soc_uart.sv
// Directed-plus-random bench for soc_uart against a frame-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_soc_uart;
    import soc_uart_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic loopback = 1'b0;
    logic rx_drv = 1'b1;
    logic irq, tx;
    wire  dut_rx;
    int   tests = 0;
    int   fails = 0;

    soc_uart_if bif();

    assign dut_rx = loopback ? tx : rx_drv;

    soc_uart #(.FIFO_AW(3), .DIV_RESET(16'd104)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .bus(bif),
        .o_irq(irq), .i_rx(dut_rx), .o_tx(tx)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, required finish before timeout");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference 8N1 frame: start 0, data LSB first, stop 1
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    function automatic int eff_div(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    task automatic bus_xfer(input logic wr, input logic [1:0] r, input logic [31:0] d,
                            output logic [31:0] q);
        int n;
        @(negedge clk);
        bif.stb = 1'b1; bif.rw = wr; bif.addr = {r, 2'b00}; bif.dwrite = d;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (bif.ack !== 1'b1 && n < 8);
        check("ack_latency", n, 1);
        q = bif.dread;
        @(posedge clk); #1;
        check("ack_one_cycle", bif.ack, 0);
        bif.stb = 1'b0; bif.rw = 1'b0;
        @(posedge clk);
    endtask

    task automatic bus_wr(input logic [1:0] r, input logic [31:0] d);
        logic [31:0] q;
        bus_xfer(1'b1, r, d, q);
    endtask

    task automatic bus_rd(input logic [1:0] r, output logic [31:0] q);
        bus_xfer(1'b0, r, 32'd0, q);
    endtask

    task automatic wait_stat(input int bitn, input int limit, input string tag);
        logic [31:0] q;
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            bus_rd(REG_STAT, q);
            ok = q[bitn];
        end
        check(tag, ok, 1);
    endtask

    // Cycle-by-cycle comparison of o_tx against the reference frame
    task automatic check_tx_frame(input logic [7:0] b, input int div, input string tag);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (tx !== 1'b0 && n < 8);
        check({tag, "_start_lat"}, n, 1);
        for (int c = 0; c < 10 * div; c++) begin
            check(tag, tx, frame_bit(b, c / div));
            @(negedge clk);
        end
        check({tag, "_line_idle"}, tx, 1);
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic stop, input int div);
        for (int k = 0; k < 10; k++) begin
            rx_drv = (k == 0) ? 1'b0 : (k == 9) ? stop : b[k-1];
            repeat (div) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        logic [31:0] q;
        logic [7:0]  b;
        logic [7:0]  bytes3 [3];
        logic [7:0]  sent_q [$];
        int          dv, acks;

        bif.stb = 1'b0; bif.rw = 1'b0; bif.addr = '0; bif.dwrite = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ack", bif.ack, 0);
        check("rst_dread", bif.dread, 0);
        check("rst_irq", irq, 0);
        check("rst_tx", tx, 1);
        rst_n = 1'b1;
        bus_rd(REG_STAT, q); check("stat_after_reset", q, 32'h4);
        bus_rd(REG_DIV, q);  check("div_after_reset", q, 32'd104);
        bus_rd(REG_CTRL, q); check("ctrl_after_reset", q, 32'd0);

        // Strobe held for several cycles yields exactly one ack
        @(negedge clk);
        bif.stb = 1'b1; bif.rw = 1'b0; bif.addr = {REG_STAT, 2'b00};
        acks = 0;
        for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (bif.ack) acks++; end
        check("held_stb_single_ack", acks, 1);
        bif.stb = 1'b0;
        @(posedge clk); @(posedge clk);

        // TX frame 0xA5 at DIV=4, then random bytes at clamped / small divisors
        bus_wr(REG_DIV, 32'd4);
        bus_wr(REG_DATA, 32'hA5);
        check_tx_frame(8'hA5, 4, "tx_a5");
        bus_rd(REG_STAT, q); check("stat_txidle_after_frame", q, 32'h4);
        for (int i = 0; i < 3; i++) begin
            dv = (i == 0) ? 1 : (i == 1) ? 0 : int'($urandom_range(2, 6));
            b  = 8'($urandom_range(0, 255));
            bus_wr(REG_DIV, 32'(dv) | 32'hABCD_0000);
            bus_rd(REG_DIV, q); check("div_readback", q, 32'(eff_div(dv)));
            bus_wr(REG_DATA, {24'hFFFFFF, b});
            check_tx_frame(b, eff_div(dv), "tx_rand");
        end

        // Loopback receive at DIV=8 with RXNE interrupt enabled
        bus_wr(REG_DIV, 32'd8);
        bus_wr(REG_CTRL, 32'h1);
        @(negedge clk); check("irq_rx_empty", irq, 0);
        loopback = 1'b1;
        bytes3[0] = 8'h3C;
        bytes3[1] = 8'($urandom_range(0, 255));
        bytes3[2] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 3; i++) begin
            bus_wr(REG_DATA, {24'd0, bytes3[i]});
            wait_stat(STAT_RXNE, 60, "rxne_set");
            check("irq_rxne", irq, 1);
            bus_rd(REG_DATA, q); check("rx_loop_byte", q, {24'd0, bytes3[i]});
            bus_rd(REG_DATA, q); check("rx_empty_read", q, 32'd0);
            bus_rd(REG_STAT, q); check("rxne_cleared", q[STAT_RXNE], 0);
            @(negedge clk); check("irq_rxne_cleared", irq, 0);
        end

        // TX FIFO fill / overflow at DIV=16; loopback overflows the RX FIFO with the 9th byte
        bus_wr(REG_DIV, 32'd16);
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom_range(0, 255));
            bus_wr(REG_DATA, {24'd0, b});
            if (i < 9) sent_q.push_back(b);
            if (i == 8) begin bus_rd(REG_STAT, q); check("stat_txfull", q, 32'h02); end
        end
        bus_rd(REG_STAT, q); check("stat_txovf", q, 32'h22);
        bus_wr(REG_STAT, 32'h20);
        bus_rd(REG_STAT, q); check("stat_txovf_cleared", q, 32'h02);
        wait_stat(STAT_TXIDLE, 600, "tx_drained");
        bus_rd(REG_STAT, q); check("stat_rxovr", q, 32'h0D);
        for (int i = 0; i < 8; i++) begin
            bus_rd(REG_DATA, q); check("rx_fifo_order", q, {24'd0, sent_q[i]});
        end
        bus_rd(REG_DATA, q); check("rx_fifo_empty_after_8", q, 32'd0);
        bus_wr(REG_STAT, 32'h08);
        bus_rd(REG_STAT, q); check("stat_rxovr_cleared", q, 32'h04);

        // Externally driven RX: good byte, false start, framing error
        loopback = 1'b0;
        bus_wr(REG_CTRL, 32'hFFFF_FFFF);
        bus_rd(REG_CTRL, q); check("ctrl_upper_zero", q, 32'h7);
        @(negedge clk); check("irq_txidle", irq, 1);
        bus_wr(REG_CTRL, 32'h0);
        bus_wr(REG_DIV, 32'd8);
        b = 8'($urandom_range(0, 255));
        drive_rx(b, 1'b1, 8);
        repeat (4) @(negedge clk);
        bus_rd(REG_STAT, q); check("stat_rx_good", q, 32'h05);
        bus_rd(REG_DATA, q); check("rx_driven_byte", q, {24'd0, b});
        rx_drv = 1'b0; repeat (2) @(negedge clk); rx_drv = 1'b1;
        repeat (16) @(negedge clk);
        bus_rd(REG_STAT, q); check("stat_false_start", q, 32'h04);
        drive_rx(8'($urandom_range(0, 255)), 1'b0, 8);
        repeat (4) @(negedge clk);
        bus_rd(REG_STAT, q); check("stat_frerr", q, 32'h14);
        check("irq_err_masked", irq, 0);
        bus_wr(REG_CTRL, 32'h4);
        @(negedge clk); check("irq_err", irq, 1);
        bus_wr(REG_STAT, 32'h10);
        @(negedge clk); check("irq_err_cleared", irq, 0);
        bus_rd(REG_STAT, q); check("stat_frerr_cleared", q, 32'h04);

        // Reset during a frame forces the line high at once
        bus_wr(REG_DIV, 32'd4);
        bus_wr(REG_DATA, {24'd0, 8'($urandom_range(0, 255))});
        acks = 0;
        do begin @(negedge clk); acks++; end while (tx !== 1'b0 && acks < 8);
        check("tx_low_before_reset", tx, 0);
        #2 rst_n = 1'b0;
        #1 check("tx_async_reset", tx, 1);
        check("irq_async_reset", irq, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bus_rd(REG_STAT, q); check("stat_after_midframe_reset", q, 32'h4);
        bus_rd(REG_DIV, q);  check("div_after_midframe_reset", q, 32'd104);
        repeat (20) @(negedge clk);
        check("tx_idle_after_reset", tx, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
